// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: fetches a 4-word line with sequential single-word reads
// and presents it to the cache as one fill pulse, stalling the pipeline meanwhile.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-7:0] fill_tag,
  output logic [1:0]            fill_set,
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] d3
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                  state_q;
  logic [1:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_rd_en_q;
  logic                    fill_valid_q;
  logic [DATA_WIDTH-1:0]   line_q [4];

  logic [ADDR_WIDTH-1:0]   line_base_d;
  logic [ADDR_WIDTH-1:0]   next_addr_d;
  logic [1:0]              cnt_inc;

  assign line_base_d = miss_addr & ~ADDR_WIDTH'(4'hF);
  assign cnt_inc     = cnt_q + 2'd1;
  // Offset stays below 16 on a 16-byte aligned base, so reads never leave the line.
  assign next_addr_d = base_q + ADDR_WIDTH'({cnt_inc, 2'b00});

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the pre-edge values of state_q, cnt_q and base_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      base_q       <= '0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      fill_valid_q <= 1'b0;
      // NOTE: the line words are only four flops, not a RAM, so they are reset
      // explicitly and read as zero until the first refill.
      for (int i = 0; i < 4; i++) line_q[i] <= '0;
    end else begin
      mem_rd_en_q  <= 1'b0;
      fill_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_req) begin
            base_q      <= line_base_d;
            cnt_q       <= 2'd0;
            mem_addr_q  <= line_base_d;
            mem_rd_en_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            line_q[cnt_q] <= mem_rdata;
            if (cnt_q == 2'd3) begin
              fill_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              cnt_q       <= cnt_inc;
              mem_addr_q  <= next_addr_d;
              mem_rd_en_q <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the pipeline freezes in the very cycle the miss appears.
  assign stall      = (state_q != IDLE) | miss_req;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign fill_valid = fill_valid_q;
  assign fill_tag   = base_q[ADDR_WIDTH-1:6];
  assign fill_set   = base_q[5:4];
  assign d0         = line_q[0];
  assign d1         = line_q[1];
  assign d2         = line_q[2];
  assign d3         = line_q[3];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: the bench plays cache and memory,
// predicting each cycle from a per-word latency schedule.
module tb_cache_refill_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [AW-1:0] miss_addr;
  logic          stall;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          fill_valid;
  logic [25:0]   fill_tag;
  logic [1:0]    fill_set;
  logic [DW-1:0] d0, d1, d2, d3;

  int total = 0;
  int bad   = 0;

  logic [3:0][31:0] exp_d;
  logic [3:0][31:0] data;
  logic [3:0][7:0]  lat;

  cache_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .stall      (stall),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .fill_valid (fill_valid),
    .fill_tag   (fill_tag),
    .fill_set   (fill_set),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag);
    check({tag, "_d0"}, 64'(d0), 64'(exp_d[0]));
    check({tag, "_d1"}, 64'(d1), 64'(exp_d[1]));
    check({tag, "_d2"}, 64'(d2), 64'(exp_d[2]));
    check({tag, "_d3"}, 64'(d3), 64'(exp_d[3]));
  endtask

  // One full refill. Cycle 0 is the acceptance cycle; read k is issued at
  // req_cyc[k] and answered lat[k] cycles after the cycle following it.
  task automatic refill(input logic [31:0] addr, input logic [3:0][7:0] l,
                        input logic [3:0][31:0] dat, input bit noise);
    logic [31:0] base;
    int req_cyc[4];
    int rv_cyc[4];
    int fill;
    base = addr & 32'hFFFF_FFF0;
    req_cyc[0] = 1;
    for (int k = 0; k < 4; k++) begin
      rv_cyc[k] = req_cyc[k] + 1 + int'(l[k]);
      if (k < 3) req_cyc[k+1] = rv_cyc[k] + 1;
    end
    fill = rv_cyc[3] + 1;
    for (int cyc = 0; cyc <= fill; cyc++) begin
      int k_req;
      int k_rv;
      k_req = -1;
      k_rv  = -1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (req_cyc[k] == cyc) k_req = k;
        if (rv_cyc[k] == cyc)  k_rv  = k;
      end
      check("mem_rd_en", 64'(mem_rd_en), 64'(k_req >= 0));
      if (k_req >= 0) check("mem_addr", 64'(mem_addr), 64'(base + 32'(4 * k_req)));
      check("fill_valid", 64'(fill_valid), 64'(cyc == fill));
      if (cyc >= 1) begin
        check("fill_tag", 64'(fill_tag), 64'(base >> 6));
        check("fill_set", 64'(fill_set), 64'((base >> 4) & 32'h3));
      end
      if (cyc == fill) begin
        exp_d = dat;
        check_line("fill");
      end
      miss_req   = (cyc == 0) ? 1'b1 : !(noise && cyc >= 4);
      miss_addr  = (cyc == 0 || !noise) ? addr : $urandom;
      mem_rvalid = (k_rv >= 0) ||
                   (noise && (cyc == 0 || k_req >= 0 || cyc == fill) && $urandom_range(1) == 1);
      mem_rdata  = (k_rv >= 0) ? dat[k_rv] : $urandom;
      #1;
      check("stall_busy", 64'(stall), 64'(1));
    end
  endtask

  // A quiet IDLE cycle: no miss, a stray rvalid, nothing may move.
  task automatic idle_step();
    @(negedge clk);
    check("idle_rd_en", 64'(mem_rd_en), 64'(0));
    check("idle_fill_valid", 64'(fill_valid), 64'(0));
    check_line("idle");
    miss_req   = 1'b0;
    miss_addr  = $urandom;
    mem_rvalid = 1'($urandom_range(1));
    mem_rdata  = $urandom;
    #1;
    check("idle_stall", 64'(stall), 64'(0));
  endtask

  initial begin
    logic [31:0] x1;

    // Reset held with no miss: every output is zero.
    rst        = 1'b1;
    miss_req   = 1'b0;
    miss_addr  = '0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    exp_d      = '0;
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_fill_valid", 64'(fill_valid), 64'(0));
    check("rst_fill_tag", 64'(fill_tag), 64'(0));
    check("rst_fill_set", 64'(fill_set), 64'(0));
    check_line("rst");
    rst = 1'b0;
    idle_step();

    // Directed single refill, then a back-to-back miss at the top of memory.
    lat  = '0;
    data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    refill(32'h0000_1234, lat, data, 1'b0);
    check("single_set", 64'(fill_set), 64'(3));
    check("single_tag", 64'(fill_tag), 64'(26'h48));
    for (int k = 0; k < 4; k++) data[k] = $urandom;
    refill(32'hFFFF_FFC0, lat, data, 1'b0);
    check("b2b_set", 64'(fill_set), 64'(0));
    check("b2b_tag", 64'(fill_tag), 64'(26'h3FF_FFFF));
    idle_step();

    // Variable latency 0,2,5,1: fill lands in cycle 17.
    lat = {8'd1, 8'd5, 8'd2, 8'd0};
    for (int k = 0; k < 4; k++) data[k] = $urandom;
    refill(32'h2468_ACE4, lat, data, 1'b0);
    idle_step();

    // Noise: stray rvalid, moving miss_addr, miss_req dropped at cycle 4.
    lat = '0;
    for (int k = 0; k < 4; k++) data[k] = $urandom;
    refill($urandom, lat, data, 1'b1);
    idle_step();

    // Asynchronous reset in the middle of WAIT, after word 0 was captured.
    x1 = $urandom | 32'h1;
    @(negedge clk);
    miss_req = 1'b1; miss_addr = $urandom; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = x1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_d0", 64'(d0), 64'(x1));
    #2 rst = 1'b1;
    #1;
    exp_d = '0;
    check_line("async_rst");
    check("async_rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("async_rst_mem_addr", 64'(mem_addr), 64'(0));
    check("async_rst_tag", 64'(fill_tag), 64'(0));
    check("async_rst_set", 64'(fill_set), 64'(0));
    check("async_rst_stall_hi", 64'(stall), 64'(1));
    miss_req = 1'b0;
    #1;
    check("async_rst_stall_lo", 64'(stall), 64'(0));
    rst = 1'b0;
    idle_step();
    idle_step();

    // Random refills: random address, latencies, data, noise and spacing.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        lat[k]  = 8'($urandom_range(3));
        data[k] = $urandom;
      end
      refill($urandom, lat, data, 1'($urandom_range(1)));
      if ($urandom_range(1) == 1) idle_step();
    end
    idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
